// File: rtl/board_cmd_engine.sv
// Command engine for a falling-block board: one command at a time through
// IDLE -> EXEC -> (LOCK | SHIFT) -> RESP, with a locked-cell array and one active shape.
module board_cmd_engine #(
    parameter int ROWS    = 20,
    parameter int COLS    = 10,
    parameter int SPAWN_X = 5,
    parameter int SPAWN_Y = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [5:0]      cmd_op,
    input  logic [1:0]      cmd_shape,
    input  logic [4:0]      cmd_arg,
    output logic            rsp_valid,
    output logic            rsp_ok,
    output logic [COLS-1:0] rsp_row,
    output logic            shape_active,
    output logic [4:0]      shape_x,
    output logic [4:0]      shape_y,
    output logic [ROWS-1:0] line_status,
    output logic            game_over
);
    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_NEW   = 6'h19;
    localparam logic [5:0] OP_LEFT  = 6'h1A;
    localparam logic [5:0] OP_RIGHT = 6'h1B;
    localparam logic [5:0] OP_DOWN  = 6'h1C;
    localparam logic [5:0] OP_REM   = 6'h1D;
    localparam logic [5:0] OP_GET   = 6'h1F;

    typedef enum logic [2:0] {IDLE, EXEC, LOCK, SHIFT, RESP} state_t;
    typedef logic [ROWS-1:0][COLS-1:0] board_t;

    state_t            state_q, state_d;
    logic [5:0]        op_q, op_d;
    logic [1:0]        shp_q, shp_d;
    logic [4:0]        arg_q, arg_d;
    board_t            board_q, board_d;
    logic              active_q, active_d;
    logic              line_q, line_d;
    logic [4:0]        x_q, x_d;
    logic [4:0]        y_q, y_d;
    logic              go_q, go_d;
    logic              ok_q, ok_d;
    logic [COLS-1:0]   row_q, row_d;
    logic [4:0]        ptr_q, ptr_d;
    board_t            cur_mask;
    logic              spawn_line;

    // Cells covered by a shape anchored at (x,y); coordinates are signed so x-1 from 0 is simply off-board.
    function automatic board_t shape_mask(input logic line, input int x, input int y);
        shape_mask = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (line) shape_mask[r][c] = (r == y) && (c >= x) && (c <= x + 3);
                else      shape_mask[r][c] = ((r == y) || (r == y + 1)) && ((c == x) || (c == x + 1));
            end
        end
    endfunction

    function automatic logic legal(input board_t b, input logic line, input int x, input int y);
        logic in_bounds;
        if (line) in_bounds = (x >= 0) && (y >= 0) && (x + 3 < COLS) && (y < ROWS);
        else      in_bounds = (x >= 0) && (y >= 0) && (x + 1 < COLS) && (y + 1 < ROWS);
        legal = in_bounds && !(|(shape_mask(line, x, y) & b));
    endfunction

    assign cur_mask   = shape_mask(line_q, int'(x_q), int'(y_q));
    assign spawn_line = (shp_q == 2'b01);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        shp_d    = shp_q;
        arg_d    = arg_q;
        board_d  = board_q;
        active_d = active_q;
        line_d   = line_q;
        x_d      = x_q;
        y_d      = y_q;
        go_d     = go_q;
        ok_d     = ok_q;
        row_d    = row_q;
        ptr_d    = ptr_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    op_d    = cmd_op;
                    shp_d   = cmd_shape;
                    arg_d   = cmd_arg;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = RESP;
                ok_d    = 1'b0;
                row_d   = '0;
                case (op_q)
                    OP_NOP: ok_d = 1'b1;
                    OP_NEW: begin
                        if (legal(board_q, spawn_line, SPAWN_X, SPAWN_Y)) begin
                            active_d = 1'b1;
                            line_d   = spawn_line;
                            x_d      = 5'(SPAWN_X);
                            y_d      = 5'(SPAWN_Y);
                            ok_d     = 1'b1;
                        end else begin
                            active_d = 1'b0;
                            go_d     = 1'b1;
                        end
                    end
                    OP_LEFT: begin
                        if (active_q && legal(board_q, line_q, int'(x_q) - 1, int'(y_q))) begin
                            x_d  = x_q - 5'd1;
                            ok_d = 1'b1;
                        end
                    end
                    OP_RIGHT: begin
                        if (active_q && legal(board_q, line_q, int'(x_q) + 1, int'(y_q))) begin
                            x_d  = x_q + 5'd1;
                            ok_d = 1'b1;
                        end
                    end
                    OP_DOWN: begin
                        if (active_q) begin
                            if (legal(board_q, line_q, int'(x_q), int'(y_q) - 1)) begin
                                y_d  = y_q - 5'd1;
                                ok_d = 1'b1;
                            end else begin
                                state_d = LOCK;
                            end
                        end
                    end
                    OP_REM: begin
                        if (int'(arg_q) < ROWS) begin
                            ptr_d   = arg_q;
                            ok_d    = 1'b1;
                            state_d = SHIFT;
                        end
                    end
                    OP_GET: begin
                        if (int'(arg_q) < ROWS) begin
                            row_d = board_q[arg_q] | (active_q ? cur_mask[arg_q] : '0);
                            ok_d  = 1'b1;
                        end
                    end
                    default: ok_d = 1'b0;
                endcase
            end
            LOCK: begin
                board_d  = board_q | cur_mask;
                active_d = 1'b0;
                state_d  = RESP;
            end
            SHIFT: begin
                // One row per cycle, bottom-up, so row r+1 is still the old content when copied.
                for (int r = 0; r < ROWS; r++) begin
                    if (r == int'(ptr_q)) board_d[r] = (r == ROWS - 1) ? '0 : board_q[(r + 1) % ROWS];
                end
                ptr_d = ptr_q + 5'd1;
                if (int'(ptr_q) == ROWS - 1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            op_q     <= '0;
            shp_q    <= '0;
            arg_q    <= '0;
            board_q  <= '0;
            active_q <= 1'b0;
            line_q   <= 1'b0;
            x_q      <= '0;
            y_q      <= '0;
            go_q     <= 1'b0;
            ok_q     <= 1'b0;
            row_q    <= '0;
            ptr_q    <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            shp_q    <= shp_d;
            arg_q    <= arg_d;
            board_q  <= board_d;
            active_q <= active_d;
            line_q   <= line_d;
            x_q      <= x_d;
            y_q      <= y_d;
            go_q     <= go_d;
            ok_q     <= ok_d;
            row_q    <= row_d;
            ptr_q    <= ptr_d;
        end
    end

    // Handshake: a command is taken on any rising edge where cmd_valid and cmd_ready are both high.
    assign cmd_ready    = (state_q == IDLE);
    assign rsp_valid    = (state_q == RESP);
    assign rsp_ok       = rsp_valid & ok_q;
    assign rsp_row      = rsp_valid ? row_q : '0;
    assign shape_active = active_q;
    assign shape_x      = x_q;
    assign shape_y      = y_q;
    assign game_over    = go_q;

    always_comb begin
        line_status = '0;
        for (int r = 0; r < ROWS; r++) line_status[r] = &board_q[r];
    end
endmodule

// File: tb/tb_board_cmd_engine.sv
// Bench for board_cmd_engine: directed vector table, hand sequences for locking,
// line removal, game over and mid-shift reset, then random commands against a board model.
module tb_board_cmd_engine;
    localparam int ROWS = 20;
    localparam int COLS = 10;
    localparam int SX   = 5;
    localparam int SY   = 16;

    localparam logic [5:0] OP_NOP   = 6'h00;
    localparam logic [5:0] OP_NEW   = 6'h19;
    localparam logic [5:0] OP_LEFT  = 6'h1A;
    localparam logic [5:0] OP_RIGHT = 6'h1B;
    localparam logic [5:0] OP_DOWN  = 6'h1C;
    localparam logic [5:0] OP_REM   = 6'h1D;
    localparam logic [5:0] OP_GET   = 6'h1F;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            cmd_valid = 1'b0;
    logic            cmd_ready;
    logic [5:0]      cmd_op = '0;
    logic [1:0]      cmd_shape = '0;
    logic [4:0]      cmd_arg = '0;
    logic            rsp_valid;
    logic            rsp_ok;
    logic [COLS-1:0] rsp_row;
    logic            shape_active;
    logic [4:0]      shape_x;
    logic [4:0]      shape_y;
    logic [ROWS-1:0] line_status;
    logic            game_over;

    int n_checks = 0;
    int n_fail   = 0;

    board_cmd_engine #(.ROWS(ROWS), .COLS(COLS), .SPAWN_X(SX), .SPAWN_Y(SY)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_shape(cmd_shape), .cmd_arg(cmd_arg),
        .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_row(rsp_row),
        .shape_active(shape_active), .shape_x(shape_x), .shape_y(shape_y),
        .line_status(line_status), .game_over(game_over)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    bit mb[ROWS][COLS];
    bit m_act, m_line, m_go;
    int m_x, m_y;

    function automatic void model_clear();
        for (int r = 0; r < ROWS; r++) for (int c = 0; c < COLS; c++) mb[r][c] = 0;
        m_act = 0; m_line = 0; m_go = 0; m_x = 0; m_y = 0;
    endfunction

    function automatic void cell_xy(input bit line, input int x, input int y, input int i,
                                    output int cx, output int cy);
        if (line) begin cx = x + i; cy = y; end
        else begin cx = x + (i % 2); cy = y + (i / 2); end
    endfunction

    function automatic bit m_fits(input bit line, input int x, input int y);
        int cx, cy;
        for (int i = 0; i < 4; i++) begin
            cell_xy(line, x, y, i, cx, cy);
            if (cx < 0 || cx >= COLS || cy < 0 || cy >= ROWS) return 0;
            if (mb[cy][cx]) return 0;
        end
        return 1;
    endfunction

    function automatic logic [COLS-1:0] m_row(input int r);
        logic [COLS-1:0] v;
        int cx, cy;
        for (int c = 0; c < COLS; c++) v[c] = mb[r][c];
        if (m_act) for (int i = 0; i < 4; i++) begin
            cell_xy(m_line, m_x, m_y, i, cx, cy);
            if (cy == r) v[cx] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [ROWS-1:0] m_full();
        logic [ROWS-1:0] v;
        for (int r = 0; r < ROWS; r++) begin
            v[r] = 1'b1;
            for (int c = 0; c < COLS; c++) if (!mb[r][c]) v[r] = 1'b0;
        end
        return v;
    endfunction

    function automatic void model_cmd(input logic [5:0] op, input logic [1:0] shp, input int arg,
                                      output logic e_ok, output logic [COLS-1:0] e_row, output int e_lat);
        int cx, cy;
        e_ok = 0; e_row = '0; e_lat = 2;
        case (op)
            OP_NOP: e_ok = 1;
            OP_NEW: begin
                if (m_fits(shp == 2'b01, SX, SY)) begin
                    m_act = 1; m_line = (shp == 2'b01); m_x = SX; m_y = SY; e_ok = 1;
                end else begin
                    m_act = 0; m_go = 1;
                end
            end
            OP_LEFT:  if (m_act && m_fits(m_line, m_x - 1, m_y)) begin m_x--; e_ok = 1; end
            OP_RIGHT: if (m_act && m_fits(m_line, m_x + 1, m_y)) begin m_x++; e_ok = 1; end
            OP_DOWN: begin
                if (m_act) begin
                    if (m_fits(m_line, m_x, m_y - 1)) begin m_y--; e_ok = 1; end
                    else begin
                        for (int i = 0; i < 4; i++) begin
                            cell_xy(m_line, m_x, m_y, i, cx, cy);
                            mb[cy][cx] = 1;
                        end
                        m_act = 0; e_lat = 3;
                    end
                end
            end
            OP_REM: begin
                if (arg < ROWS) begin
                    for (int r = arg; r < ROWS - 1; r++) for (int c = 0; c < COLS; c++) mb[r][c] = mb[r+1][c];
                    for (int c = 0; c < COLS; c++) mb[ROWS-1][c] = 0;
                    e_ok = 1; e_lat = 2 + ROWS - arg;
                end
            end
            OP_GET: if (arg < ROWS) begin e_row = m_row(arg); e_ok = 1; end
            default: e_ok = 0;
        endcase
    endfunction

    // ---------------- checking and drivers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("rsp_valid_in_reset", 32'(rsp_valid), 0);
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check("rst_cmd_ready", 32'(cmd_ready), 1);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_ok", 32'(rsp_ok), 0);
        check("rst_rsp_row", 32'(rsp_row), 0);
        check("rst_shape_active", 32'(shape_active), 0);
        check("rst_shape_x", 32'(shape_x), 0);
        check("rst_shape_y", 32'(shape_y), 0);
        check("rst_game_over", 32'(game_over), 0);
        check("rst_line_status", 32'(line_status), 0);
    endtask

    // Issues one command, checks it against the model; starts and ends just after a falling edge.
    task automatic do_cmd(input logic [5:0] op, input logic [1:0] shp, input logic [4:0] arg,
                          output logic got_ok, output logic [COLS-1:0] got_row, output int got_lat);
        logic e_ok;
        logic [COLS-1:0] e_row;
        int e_lat;
        int n;
        model_cmd(op, shp, int'(arg), e_ok, e_row, e_lat);
        check("cmd_ready_idle", 32'(cmd_ready), 1);
        cmd_valid = 1'b1; cmd_op = op; cmd_shape = shp; cmd_arg = arg;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 1;
        check("cmd_ready_busy", 32'(cmd_ready), 0);
        while (!rsp_valid && n < 40) begin
            if (rsp_ok !== 1'b0 || rsp_row !== '0) check("rsp_gated", {rsp_ok, 21'd0, rsp_row}, 0);
            @(negedge clk);
            n++;
        end
        got_ok = rsp_ok; got_row = rsp_row; got_lat = n;
        if (!rsp_valid) check("rsp_timeout", 32'(rsp_valid), 1);
        check("rsp_latency", n, e_lat);
        check("rsp_ok", 32'(rsp_ok), 32'(e_ok));
        check("rsp_row", 32'(rsp_row), 32'(e_row));
        @(negedge clk);
        check("rsp_one_cycle", 32'(rsp_valid), 0);
        check("cmd_ready_after", 32'(cmd_ready), 1);
        check("shape_active", 32'(shape_active), 32'(m_act));
        if (m_act) begin
            check("shape_x", 32'(shape_x), m_x);
            check("shape_y", 32'(shape_y), m_y);
        end
        check("game_over", 32'(game_over), 32'(m_go));
        check("line_status", 32'(line_status), 32'(m_full()));
    endtask

    task automatic drop(input logic [1:0] shp, input int dx);
        logic ok;
        logic [COLS-1:0] row;
        int lat;
        bit locked;
        do_cmd(OP_NEW, shp, 5'd0, ok, row, lat);
        for (int i = 0; i < (dx < 0 ? -dx : dx); i++)
            do_cmd(dx < 0 ? OP_LEFT : OP_RIGHT, 2'd0, 5'd0, ok, row, lat);
        locked = 0;
        for (int i = 0; i < 25 && !locked; i++) begin
            do_cmd(OP_DOWN, 2'd0, 5'd0, ok, row, lat);
            if (!ok) locked = 1;
        end
        check("drop_locked", 32'(locked), 1);
    endtask

    typedef struct {
        logic [5:0]      op;
        logic [1:0]      shp;
        logic [4:0]      arg;
        logic            ok;
        logic [COLS-1:0] row;
        int              x;
        int              y;
        logic            act;
        int              lat;
    } vec_t;

    vec_t vecs[14];

    initial begin
        logic ok;
        logic [COLS-1:0] row;
        int lat;
        bit seen;
        logic [5:0] op;

        vecs[0]  = '{OP_NEW,   2'd0, 5'd0,  1'b1, 10'h000, 5, 16, 1'b1, 2};
        vecs[1]  = '{OP_LEFT,  2'd0, 5'd0,  1'b1, 10'h000, 4, 16, 1'b1, 2};
        vecs[2]  = '{OP_LEFT,  2'd0, 5'd0,  1'b1, 10'h000, 3, 16, 1'b1, 2};
        vecs[3]  = '{OP_LEFT,  2'd0, 5'd0,  1'b1, 10'h000, 2, 16, 1'b1, 2};
        vecs[4]  = '{OP_LEFT,  2'd0, 5'd0,  1'b1, 10'h000, 1, 16, 1'b1, 2};
        vecs[5]  = '{OP_LEFT,  2'd0, 5'd0,  1'b1, 10'h000, 0, 16, 1'b1, 2};
        vecs[6]  = '{OP_LEFT,  2'd0, 5'd0,  1'b0, 10'h000, 0, 16, 1'b1, 2};
        vecs[7]  = '{OP_NEW,   2'd1, 5'd0,  1'b1, 10'h000, 5, 16, 1'b1, 2};
        vecs[8]  = '{OP_RIGHT, 2'd0, 5'd0,  1'b1, 10'h000, 6, 16, 1'b1, 2};
        vecs[9]  = '{OP_RIGHT, 2'd0, 5'd0,  1'b0, 10'h000, 6, 16, 1'b1, 2};
        vecs[10] = '{OP_NOP,   2'd0, 5'd0,  1'b1, 10'h000, 6, 16, 1'b1, 2};
        vecs[11] = '{6'h3F,    2'd0, 5'd0,  1'b0, 10'h000, 6, 16, 1'b1, 2};
        vecs[12] = '{OP_GET,   2'd0, 5'd16, 1'b1, 10'h3C0, 6, 16, 1'b1, 2};
        vecs[13] = '{OP_GET,   2'd0, 5'd25, 1'b0, 10'h000, 6, 16, 1'b1, 2};

        do_reset();

        for (int i = 0; i < 14; i++) begin
            do_cmd(vecs[i].op, vecs[i].shp, vecs[i].arg, ok, row, lat);
            check($sformatf("vec%0d_ok", i), 32'(ok), 32'(vecs[i].ok));
            check($sformatf("vec%0d_row", i), 32'(row), 32'(vecs[i].row));
            check($sformatf("vec%0d_lat", i), lat, vecs[i].lat);
            check($sformatf("vec%0d_x", i), 32'(shape_x), vecs[i].x);
            check($sformatf("vec%0d_y", i), 32'(shape_y), vecs[i].y);
            check($sformatf("vec%0d_act", i), 32'(shape_active), 32'(vecs[i].act));
        end

        // Square falls 16 rows, 17th move locks it at the bottom.
        do_reset();
        do_cmd(OP_NEW, 2'd0, 5'd0, ok, row, lat);
        for (int i = 0; i < 16; i++) begin
            do_cmd(OP_DOWN, 2'd0, 5'd0, ok, row, lat);
            check("down_ok", 32'(ok), 1);
        end
        check("down_y0", 32'(shape_y), 0);
        do_cmd(OP_DOWN, 2'd0, 5'd0, ok, row, lat);
        check("lock_ok", 32'(ok), 0);
        check("lock_lat", lat, 3);
        check("lock_inactive", 32'(shape_active), 0);
        do_cmd(OP_GET, 2'd0, 5'd0, ok, row, lat);
        check("lock_row0", 32'(row), 32'h060);
        do_cmd(OP_GET, 2'd0, 5'd1, ok, row, lat);
        check("lock_row1", 32'(row), 32'h060);

        // Fill row 0 with two lines and a square, then remove it.
        do_reset();
        drop(2'd1, -5);
        drop(2'd1, -1);
        drop(2'd0, 3);
        check("full_row0", 32'(line_status[0]), 1);
        do_cmd(OP_REM, 2'd0, 5'd0, ok, row, lat);
        check("rem_ok", 32'(ok), 1);
        check("rem_lat", lat, 22);
        check("rem_line_status0", 32'(line_status[0]), 0);
        do_cmd(OP_GET, 2'd0, 5'd0, ok, row, lat);
        check("rem_row0", 32'(row), 32'h300);
        do_cmd(OP_GET, 2'd0, 5'd19, ok, row, lat);
        check("rem_row19", 32'(row), 0);
        do_cmd(OP_REM, 2'd0, 5'd20, ok, row, lat);
        check("rem_bad_ok", 32'(ok), 0);

        // Stack squares in columns 5,6 up to row 17; next spawn collides.
        do_reset();
        for (int i = 0; i < 9; i++) drop(2'd0, 0);
        do_cmd(OP_NEW, 2'd0, 5'd0, ok, row, lat);
        check("go_spawn_ok", 32'(ok), 0);
        check("go_flag", 32'(game_over), 1);
        do_cmd(OP_GET, 2'd0, 5'd25, ok, row, lat);
        check("go_get25_ok", 32'(ok), 0);
        check("go_get25_row", 32'(row), 0);
        do_cmd(OP_GET, 2'd0, 5'd16, ok, row, lat);
        check("go_get16", 32'(row), 32'h060);

        // Reset while REMOVE_LINE is shifting.
        do_reset();
        drop(2'd0, 0);
        cmd_valid = 1'b1; cmd_op = OP_REM; cmd_shape = 2'd0; cmd_arg = 5'd0;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        seen = 0;
        repeat (4) begin
            if (rsp_valid) seen = 1;
            @(negedge clk);
        end
        #2 rst = 1'b1;
        #1 if (rsp_valid) seen = 1;
        repeat (2) @(negedge clk);
        if (rsp_valid) seen = 1;
        rst = 1'b0;
        model_clear();
        @(negedge clk);
        check("midshift_no_rsp", 32'(seen), 0);
        check("midshift_ready", 32'(cmd_ready), 1);
        check("midshift_lines", 32'(line_status), 0);
        for (int r = 0; r < ROWS; r++) begin
            do_cmd(OP_GET, 2'd0, 5'(r), ok, row, lat);
            check("midshift_row_clear", 32'(row), 0);
        end

        // Random commands against the model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 15))
                0, 1:          op = OP_NEW;
                2, 3:          op = OP_LEFT;
                4, 5:          op = OP_RIGHT;
                6, 7, 8, 9, 10: op = OP_DOWN;
                11:            op = OP_REM;
                12, 15:        op = OP_GET;
                13:            op = OP_NOP;
                default: begin
                    op = 6'($urandom_range(1, 63));
                    if (op inside {OP_NEW, OP_LEFT, OP_RIGHT, OP_DOWN, OP_REM, OP_GET}) op = 6'h1E;
                end
            endcase
            do_cmd(op, 2'($urandom_range(0, 1)), 5'($urandom_range(0, 24)), ok, row, lat);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #600000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached, failures=%0d", n_fail);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end
endmodule
